apa102_strip_ctrl: RTL and testbench

- Wishbone-slave controller for an APA102/Blinkt-style LED chain of parametrised length.
- Holds one 32-bit register per LED.
- On command, or continuously in auto mode, serialises start frame, LED frames and end frame on o_led_clk/o_led_data with an internal clock divider.
- Replaces the fixed 8-LED bar controller and its external serializer; sits on the serial-to-Wishbone bus fabric.

---
 rtl/apa102_strip_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_apa102_strip_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apa102_strip_ctrl.sv
// Wishbone-mapped APA102 LED chain controller: one 32-bit register per LED,
// serialised as start frame, LED frames and end frame on a divided LED clock.
module apa102_strip_ctrl #(
  parameter int NUM_LEDS     = 8,
  parameter int CLK_DIV      = 120,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic                    wb_we_i,
  input  logic [SELECT_WIDTH-1:0] wb_sel_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_cyc_i,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  output logic                    o_led_clk,
  output logic                    o_led_data
);
  // state | meaning
  // IDLE  | line quiet, waiting for START, PENDING, relaunch or AUTO
  // LOAD  | latch next word (start/LED/end) into shift register
  // SHIFT | clock out 32 bits of the current word
  // DONE  | bump frame counter, clear PENDING
  localparam int END_WORDS = (NUM_LEDS + 63) / 64;
  localparam int WCNT_W    = 6;
  localparam int IDX_W     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [WCNT_W-1:0] NUM_W  = WCNT_W'(NUM_LEDS);
  localparam logic [WCNT_W-1:0] LAST_W = WCNT_W'(NUM_LEDS + END_WORDS);
  localparam logic [15:0] DIV_RELOAD = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state, state_nx;

  logic [31:0]       leds [NUM_LEDS];
  logic              ctrl_auto, pending, relaunch;
  logic [7:0]        frame_cnt;
  logic [15:0]       div_cnt;
  logic [4:0]        bit_cnt;
  logic [WCNT_W-1:0] word_cnt;
  logic [30:0]       sreg, word_nx;
  logic              busy, done_en, shift_end;

  logic [7:0]       off;
  logic             req, hit_ctrl, hit_stat, hit_led, mapped, start_req;
  logic [IDX_W-1:0] led_idx;
  logic [31:0]      rd_val;
  logic             unused_adr;

  assign off        = wb_adr_i[7:0];
  assign unused_adr = ^wb_adr_i[ADDR_WIDTH-1:8];
  assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign hit_ctrl   = (off == 8'h00);
  assign hit_stat   = (off == 8'h04);
  assign hit_led    = off[7] && (off[1:0] == 2'b00) && ({1'b0, off[6:2]} < NUM_W);
  assign mapped     = hit_ctrl | hit_stat | hit_led;
  assign led_idx    = IDX_W'(off[6:2]);
  assign start_req  = req & wb_we_i & hit_ctrl & wb_sel_i[0] & wb_dat_i[0];
  assign wb_rty_o   = 1'b0;

  always_comb begin
    rd_val = '0;
    if (hit_ctrl)      rd_val = {30'b0, ctrl_auto, 1'b0};
    else if (hit_stat) rd_val = {16'b0, frame_cnt, 6'b0, pending, busy};
    else if (hit_led)  rd_val = leds[led_idx];
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      wb_dat_o  <= '0;
      ctrl_auto <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) leds[i] <= '0;
    end else begin
      wb_ack_o <= req & mapped;
      wb_err_o <= req & ~mapped;
      wb_dat_o <= (req & mapped) ? rd_val : '0;
      if (req & wb_we_i) begin
        if (hit_ctrl && wb_sel_i[0]) ctrl_auto <= wb_dat_i[1];
        if (hit_led)
          for (int b = 0; b < 4; b++)
            if (wb_sel_i[b]) leds[led_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

  // A START landing in DONE is folded into the relaunch instead of PENDING.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pending   <= 1'b0;
      relaunch  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      relaunch <= done_en & (pending | start_req);
      if (done_en)                pending <= 1'b0;
      else if (start_req && busy) pending <= 1'b1;
      if (done_en) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_req | pending | relaunch | ctrl_auto) state_nx = LOAD;
      LOAD:    state_nx = SHIFT;
      SHIFT:   if (shift_end) state_nx = (word_cnt <= LAST_W) ? LOAD : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done_en   = (state == DONE);
    shift_end = (state == SHIFT) && o_led_clk && (div_cnt == '0) && (bit_cnt == '0);
  end

  always_comb begin
    word_nx = '1;
    if (word_cnt == '0)        word_nx = '0;
    else if (word_cnt <= NUM_W) word_nx = {2'b11, leds[IDX_W'(word_cnt - 1'b1)][28:0]};
  end

  // The LOAD cycle doubles as the first low-phase cycle of the word's MSB, whose
  // value is fixed by word position, so it is driven on the falling edge before LOAD.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_led_clk  <= 1'b0;
      o_led_data <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      sreg       <= '0;
    end else begin
      case (state)
        IDLE: begin
          word_cnt   <= '0;
          div_cnt    <= DIV_RELOAD;
          o_led_clk  <= 1'b0;
          o_led_data <= 1'b0;
        end
        LOAD: begin
          sreg     <= word_nx;
          bit_cnt  <= 5'd31;
          word_cnt <= word_cnt + 1'b1;
          if (div_cnt == '0) begin
            o_led_clk <= 1'b1;
            div_cnt   <= DIV_RELOAD;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt <= DIV_RELOAD;
            if (!o_led_clk) begin
              o_led_clk <= 1'b1;
            end else begin
              o_led_clk <= 1'b0;
              if (bit_cnt != '0) begin
                bit_cnt    <= bit_cnt - 1'b1;
                o_led_data <= sreg[30];
                sreg       <= {sreg[29:0], 1'b0};
              end else begin
                o_led_data <= (word_cnt <= LAST_W);
              end
            end
          end
        end
        default: begin
          o_led_clk  <= 1'b0;
          o_led_data <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apa102_strip_ctrl.sv
// Self-checking bench for apa102_strip_ctrl: register vectors, frame capture
// against a bit-list model, pending/auto/reset corner sequences.
`timescale 1ns/1ps
module tb_apa102_strip_ctrl;
  localparam int N          = 2;
  localparam int DIV        = 2;
  localparam int FRAME_BITS = 32 * (N + 1 + (N + 63) / 64);
  localparam int BIT_NS     = 2 * DIV * 10;
  localparam int GAP_NS     = BIT_NS + 20;

  logic        clk, rst, we, stb, cyc, ack, err, rty, led_clk, led_data;
  logic [31:0] adr, dat_w, dat_r;
  logic [3:0]  sel;

  apa102_strip_ctrl #(.NUM_LEDS(N), .CLK_DIV(DIV)) dut (
    .i_clk(clk), .i_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_r),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack),
    .wb_err_o(err), .wb_rty_o(rty), .o_led_clk(led_clk), .o_led_data(led_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0, failures = 0;
  logic cap_bits[$];
  logic exp_bits[$];
  time  rise_t[$];
  logic [31:0] m_led [N];
  int   m_frames = 0;

  always @(posedge led_clk) begin
    cap_bits.push_back(led_data);
    rise_t.push_back($time);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic ak, output logic er);
    int n = 0;
    @(negedge clk);
    cyc = 1; stb = 1; adr = a; we = w; dat_w = d; sel = s;
    do begin @(posedge clk); #1; n++; end while (!ack && !err && n < 8);
    rd = dat_r; ak = ack; er = err;
    cyc = 0; stb = 0; we = 0;
    if (!ak && !er) begin
      checks++; failures++;
      $display("FAIL wb_timeout actual=no_response required=ack_or_err adr=0x%08h", a);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd; logic ak, er;
    xfer(a, 1'b1, d, s, rd, ak, er);
    check("wr_ack", {31'b0, ak}, 32'd1);
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
    logic ak, er;
    xfer(a, 1'b0, 32'h0, 4'hF, d, ak, er);
  endtask

  task automatic wait_idle(input int exp_cnt, input int max_reads, output logic [31:0] st);
    int c = 0;
    do begin rd_reg(32'h04, st); c++; end
    while (!(st[0] == 1'b0 && st[15:8] == 8'(exp_cnt)) && c < max_reads);
    if (!(st[0] == 1'b0 && st[15:8] == 8'(exp_cnt))) begin
      checks++; failures++;
      $display("FAIL wait_idle actual=0x%08h required_cnt=%0d", st, exp_cnt);
    end
  endtask

  task automatic wait_bits(input int n, input int budget);
    int c = 0;
    while (cap_bits.size() < n && c < budget) begin @(posedge clk); #1; c++; end
    if (cap_bits.size() < n) begin
      checks++; failures++;
      $display("FAIL wait_bits actual=%0d required=%0d", cap_bits.size(), n);
    end
  endtask

  task automatic add_frame();
    logic [31:0] w;
    for (int b = 0; b < 32; b++) exp_bits.push_back(1'b0);
    for (int i = 0; i < N; i++) begin
      w = {3'b111, m_led[i][28:0]};
      for (int b = 31; b >= 0; b--) exp_bits.push_back(w[b]);
    end
    for (int e = 0; e < (N + 63) / 64; e++)
      for (int b = 0; b < 32; b++) exp_bits.push_back(1'b1);
  endtask

  task automatic cmp_stream(input string name);
    int bad = 0;
    check({name, "_len"}, cap_bits.size(), exp_bits.size());
    for (int k = 0; k < exp_bits.size() && k < cap_bits.size(); k++)
      if (cap_bits[k] !== exp_bits[k]) bad++;
    check({name, "_bits"}, bad, 0);
  endtask

  task automatic check_gaps(input string name);
    int bad = 0;
    time g;
    for (int k = 0; k + 1 < rise_t.size(); k++) begin
      g = (((k + 1) % FRAME_BITS) == 0) ? GAP_NS : BIT_NS;
      if (rise_t[k+1] - rise_t[k] != g) bad++;
    end
    check(name, bad, 0);
  endtask

  function automatic logic [31:0] cap_word(input int j);
    logic [31:0] w = '0;
    for (int b = 0; b < 32; b++)
      w = {w[30:0], (32*j + b < cap_bits.size()) ? cap_bits[32*j + b] : 1'b0};
    return w;
  endfunction

  task automatic clear_cap();
    cap_bits.delete(); rise_t.delete(); exp_bits.delete();
  endtask

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_dat;
    logic        exp_err;
  } vec_t;
  vec_t vt[19];

  initial begin
    logic [31:0] d, st, v;
    logic ak, er;
    logic [3:0] s;
    time t0;
    int  dur, fin, base;

    vt[0]  = '{32'h00,       0, 32'h0,        4'hF, 32'h0,        0};
    vt[1]  = '{32'h04,       0, 32'h0,        4'hF, 32'h0,        0};
    vt[2]  = '{32'h80,       0, 32'h0,        4'hF, 32'h0,        0};
    vt[3]  = '{32'h84,       0, 32'h0,        4'hF, 32'h0,        0};
    vt[4]  = '{32'h40,       1, 32'h12345678, 4'hF, 32'h0,        1};
    vt[5]  = '{32'h40,       0, 32'h0,        4'hF, 32'h0,        1};
    vt[6]  = '{32'h80,       1, 32'hAABBCCDD, 4'h2, 32'h0,        0};
    vt[7]  = '{32'h80,       0, 32'h0,        4'hF, 32'h0000CC00, 0};
    vt[8]  = '{32'h88,       0, 32'h0,        4'hF, 32'h0,        1};
    vt[9]  = '{32'h82,       0, 32'h0,        4'hF, 32'h0,        1};
    vt[10] = '{32'h84,       1, 32'h11223344, 4'h9, 32'h0,        0};
    vt[11] = '{32'h84,       0, 32'h0,        4'hF, 32'h11000044, 0};
    vt[12] = '{32'hFFFFFF80, 0, 32'h0,        4'hF, 32'h0000CC00, 0};
    vt[13] = '{32'h00,       1, 32'h00000002, 4'hE, 32'h0,        0};
    vt[14] = '{32'h00,       0, 32'h0,        4'hF, 32'h0,        0};
    vt[15] = '{32'h04,       1, 32'h0000FFFF, 4'hF, 32'h0,        0};
    vt[16] = '{32'h04,       0, 32'h0,        4'hF, 32'h0,        0};
    vt[17] = '{32'h1C0,      1, 32'hDEADBEEF, 4'hF, 32'h0,        1};
    vt[18] = '{32'h84,       0, 32'h0,        4'hF, 32'h11000044, 0};

    rst = 1; cyc = 0; stb = 0; we = 0; adr = 0; dat_w = 0; sel = 0;
    #2 rst = 0;
    #1;
    check("rst_led_clk", {31'b0, led_clk}, 0);
    check("rst_led_data", {31'b0, led_data}, 0);
    check("rst_ack", {31'b0, ack}, 0);
    check("rst_err", {31'b0, err}, 0);
    repeat (3) @(negedge clk);
    rst = 1;
    check("rty", {31'b0, rty}, 0);

    // register vectors
    foreach (vt[i]) begin
      xfer(vt[i].adr, vt[i].we, vt[i].dat, vt[i].sel, d, ak, er);
      check($sformatf("vec%0d_ack", i), {31'b0, ak}, {31'b0, ~vt[i].exp_err});
      check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vt[i].exp_err});
      if (!vt[i].we || vt[i].exp_err) check($sformatf("vec%0d_dat", i), d, vt[i].exp_dat);
    end
    m_led[0] = 32'h0000CC00; m_led[1] = 32'h11000044;

    // err pulse lasts exactly one cycle
    xfer(32'h40, 1'b1, 32'h0, 4'hF, d, ak, er);
    @(posedge clk); #1;
    check("err_one_cycle", {30'b0, err, ack}, 0);

    // reference frame
    wr(32'h80, 32'h1F0000FF, 4'hF); m_led[0] = 32'h1F0000FF;
    wr(32'h84, 32'h01123456, 4'hF); m_led[1] = 32'h01123456;
    clear_cap(); add_frame();
    wr(32'h00, 32'h1, 4'h1);
    t0 = $time - 1;
    wait_idle(1, 2000, st); m_frames = 1;
    dur = int'(($time - 1 - t0) / 10) - 1;
    check("busy_cycles_in_510_514", {31'b0, (dur >= 510 && dur <= 514)}, 1);
    check("w0", cap_word(0), 32'h00000000);
    check("w1", cap_word(1), 32'hFF0000FF);
    check("w2", cap_word(2), 32'hE1123456);
    check("w3", cap_word(3), 32'hFFFFFFFF);
    cmp_stream("ref_frame");
    check_gaps("ref_gaps");
    check("status_after_ref", st, 32'h00000100);
    check("led_clk_idle", {31'b0, led_clk}, 0);

    // LED1 written before it is loaded counts; LED0 written after its load does not
    clear_cap();
    wr(32'h00, 32'h1, 4'h1);
    v = $urandom; wr(32'h84, v, 4'hF); m_led[1] = v;
    add_frame();
    wait_bits(40, 400);
    v = $urandom; wr(32'h80, v, 4'hF);
    wait_idle(m_frames + 1, 2000, st); m_frames++;
    m_led[0] = v;
    cmp_stream("late_write");

    // randomized byte-lane writes and frames
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        v = $urandom; s = 4'($urandom_range(1, 15));
        wr(32'h80 + 4*i, v, s);
        for (int b = 0; b < 4; b++) if (s[b]) m_led[i][8*b +: 8] = v[8*b +: 8];
        rd_reg(32'h80 + 4*i, d);
        check($sformatf("rand%0d_led%0d", r, i), d, m_led[i]);
      end
      clear_cap(); add_frame();
      wr(32'h00, 32'h1, 4'h1);
      wait_idle(m_frames + 1, 2000, st); m_frames++;
      cmp_stream($sformatf("rand%0d_frame", r));
    end

    // three STARTs during one frame collapse to two frames
    clear_cap(); add_frame(); add_frame();
    wr(32'h00, 32'h1, 4'h1);
    wait_bits(10, 200);
    wr(32'h00, 32'h1, 4'h1);
    rd_reg(32'h04, st);
    check("pending_set", {30'b0, st[1:0]}, 32'h3);
    wr(32'h00, 32'h1, 4'h1);
    wait_idle(m_frames + 2, 3000, st); m_frames += 2;
    check("pending_status", st, {16'b0, 8'(m_frames), 8'b0});
    cmp_stream("pending_frames");
    check_gaps("pending_gaps");

    // AUTO: back-to-back frames, clearing AUTO lets the current frame finish
    clear_cap();
    base = m_frames;
    wr(32'h00, 32'h2, 4'h1);
    wait_bits(3 * FRAME_BITS + 20, 3000);
    wr(32'h00, 32'h0, 4'h1);
    rd_reg(32'h04, st);
    fin = int'(st[15:8]) + int'(st[0]);
    wait_idle(fin, 2000, st);
    m_frames = fin;
    check("auto_frames_ge3", {31'b0, (fin - base) >= 3}, 1);
    for (int f = 0; f < fin - base; f++) add_frame();
    cmp_stream("auto_frames");
    check_gaps("auto_gaps");
    rd_reg(32'h00, d);
    check("auto_cleared", d, 0);

    // reset in the middle of an LED word
    clear_cap();
    wr(32'h00, 32'h1, 4'h1);
    wait_bits(33, 400);
    check("pre_rst_line", {30'b0, led_clk, led_data}, 32'h3);
    #2 rst = 0;
    #1;
    check("async_rst_line", {30'b0, led_clk, led_data}, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    m_led[0] = 0; m_led[1] = 0; m_frames = 0;
    rd_reg(32'h04, d); check("post_rst_status", d, 0);
    rd_reg(32'h80, d); check("post_rst_led0", d, 0);
    rd_reg(32'h00, d); check("post_rst_ctrl", d, 0);
    clear_cap(); add_frame();
    wr(32'h00, 32'h1, 4'h1);
    wait_idle(1, 2000, st);
    cmp_stream("post_rst_frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
